tlu_readout_arbiter: RTL and testbench
======================================

Name: tlu_readout_arbiter

Overview:
Shares one downstream 32-bit readout stream between N first-word-fall-through data FIFOs. Sources include the TLU slave FIFO, TDC FIFOs and pixel-data FIFOs. Arbitration is round-robin with bounded bursts. A source asserting FIFO_PREEMPT_REQ (e.g. the TLU trigger word) gets priority and keeps the grant until its FIFO drains. The block sits between the per-IP FIFO ports and the SiTCP/USB readout FIFO writer.

Parameters:
N_SRC, 4, number of requesting sources (2..8)
DATA_WIDTH, 32, word width of every source and of the output
MAX_BURST, 16, max words per grant for a non-preempting source (1..255)
SRC_W, $clog2(N_SRC), width of the source index (derived, localparam)

Ports:
BUS_CLK  input  1  single clock for all logic
BUS_RST_N  input  1  asynchronous, active-low reset
SRC_ENABLE  input  N_SRC  per-source arbitration mask; 1 = may be granted
SRC_FIFO_EMPTY  input  N_SRC  per-source FWFT empty flag
SRC_FIFO_DATA  input  N_SRC*DATA_WIDTH  flat bus; source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
SRC_FIFO_PREEMPT_REQ  input  N_SRC  per-source priority request
SRC_FIFO_READ  output  N_SRC  per-source pop strobe, one-hot or zero
OUT_DATA  output  DATA_WIDTH  word of the granted source
OUT_VALID  output  1  OUT_DATA is valid
OUT_READY  input  1  downstream accepts the word when OUT_VALID & OUT_READY
GRANT  output  N_SRC  registered one-hot grant (0 in IDLE)
GRANT_ID  output  SRC_W  index of the granted source (0 in IDLE)
BUSY  output  1  high in state XFER

Behaviour:
- Reset (async assert) clears these immediately: state=IDLE, GRANT=0, GRANT_ID=0, rr_ptr=0, burst_cnt=0. OUT_VALID=0, SRC_FIFO_READ=0, BUSY=0. OUT_DATA is forced to 0 while GRANT=0.
- Reset mid-burst: un-popped words stay in the sources; no word is popped during or after the reset edge.
- Request definition: req[i] = SRC_ENABLE[i] & ~SRC_FIFO_EMPTY[i]. Priority request: preq[i] = req[i] & SRC_FIFO_PREEMPT_REQ[i].
- FSM states are IDLE and XFER.
- IDLE, when req is nonzero:
  - Choose the winner: if preq is nonzero, first set bit of preq searching rr_ptr, rr_ptr+1, ... mod N_SRC; otherwise the first set bit of req in the same order.
  - Register GRANT/GRANT_ID, burst_cnt=0, move to XFER.
  - Latency: req seen at edge k; OUT_VALID can be high from edge k+1.
- XFER, combinational outputs:
  - OUT_VALID = ~SRC_FIFO_EMPTY[g].
  - OUT_DATA = data of source g.
  - SRC_FIFO_READ[g] = OUT_VALID & OUT_READY; all other bits 0.
- XFER, counting: burst_cnt increments on each transfer and saturates at 255.
- XFER, release to IDLE at the edge where any of these holds:
  - a) SRC_FIFO_EMPTY[g]=1 (no transfer in that cycle).
  - b) A transfer occurs, burst_cnt+1 == MAX_BURST, and SRC_FIFO_PREEMPT_REQ[g]=0.
  - c) A transfer occurs, SRC_FIFO_PREEMPT_REQ[g]=0, and preq is nonzero for some other source.
- On release: rr_ptr = (g+1) mod N_SRC, GRANT=0. This gives one idle gap cycle between grants.
- Preempting source: while SRC_FIFO_PREEMPT_REQ[g]=1 the burst limit is ignored; release only via a).
- SRC_ENABLE falling for the granted source does not cut the grant; the mask acts only at arbitration.
- Backpressure: with OUT_READY=0, no pop, OUT_DATA stays stable, burst_cnt holds, and no release by b) or c).
- Simultaneous cases: several preq bits resolve round-robin from rr_ptr. If req=0 in IDLE, the FSM stays in IDLE and rr_ptr is unchanged.
- Invariant: SRC_FIFO_READ[i] never asserts while SRC_FIFO_EMPTY[i]=1.

Decomposition:
- Shared package tlu_readout_pkg: state enum (IDLE, XFER) and a clog2-based SRC_W helper.
- One sub-module rr_priority_select. Combinational. Inputs: request vector, rr_ptr. Outputs: one-hot and index of the first set bit at or after rr_ptr.
- It is instantiated twice: once for preq, once for req.

Test Plan:
- Reset values: hold BUS_RST_N=0 -> all outputs 0; release -> IDLE, GRANT=0.
- Single source: src1 holds 3 words, OUT_READY=1. Required response:
  - GRANT=4'b0010 one cycle after EMPTY falls;
  - 3 consecutive pops with data matching;
  - IDLE on the empty cycle, then rr_ptr=2.
- Burst limit: MAX_BURST=4, src0 and src3 always non-empty -> alternating bursts of exactly 4 words (0,3,0,3) with one gap cycle each.
- Preemption: src0 streaming; src2 asserts PREEMPT_REQ after src0's 2nd word -> src0 released after the word in that cycle, then src2 granted. src2 has 20 words -> all 20 sent in one grant despite MAX_BURST=16.
- Backpressure: OUT_READY toggles 1,0,0,1 during a grant -> pops only on READY=1, OUT_DATA stable while READY=0, burst_cnt advances 2 in 4 cycles.
- Mask and async reset:
  - SRC_ENABLE=4'b1101 with src1 non-empty -> src1 never granted.
  - Assert BUS_RST_N=0 mid-burst (no clock edge needed) -> SRC_FIFO_READ, OUT_VALID and GRANT drop to 0 immediately.

Source files
------------

// File: rtl/tlu_readout_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tlu_readout_pkg: shared FSM encoding and sizing helpers for the
// readout arbiter.  Rev 1.0
// ------------------------------------------------------------------
package tlu_readout_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam int         BURST_CNT_W = 8;
  localparam logic [7:0] BURST_SAT   = 8'hFF;

  // A single source still needs a one-bit index.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_select.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_priority_select: first set request bit at or after ptr_i, wrapping.
// Rev 1.0
// ------------------------------------------------------------------
module rr_priority_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o
);

  int j;

  // Walk from the farthest candidate back to ptr_i so the nearest one wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    j        = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j[W-1:0]]) begin
        onehot_o           = '0;
        onehot_o[j[W-1:0]] = 1'b1;
        idx_o              = j[W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlu_readout_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tlu_readout_arbiter: round-robin, burst-limited sharing of one readout
// stream between N FWFT FIFOs, with drain-until-empty preemption.  Rev 1.0
// ------------------------------------------------------------------
module tlu_readout_arbiter
  import tlu_readout_pkg::*;
#(
  parameter int  N_SRC      = 4,
  parameter int  DATA_WIDTH = 32,
  parameter int  MAX_BURST  = 16,
  localparam int SRC_W      = src_w(N_SRC)
) (
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST_N,
  input  logic [N_SRC-1:0]            SRC_ENABLE,
  input  logic [N_SRC-1:0]            SRC_FIFO_EMPTY,
  input  logic [N_SRC*DATA_WIDTH-1:0] SRC_FIFO_DATA,
  input  logic [N_SRC-1:0]            SRC_FIFO_PREEMPT_REQ,
  output logic [N_SRC-1:0]            SRC_FIFO_READ,
  output logic [DATA_WIDTH-1:0]       OUT_DATA,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [N_SRC-1:0]            GRANT,
  output logic [SRC_W-1:0]            GRANT_ID,
  output logic                        BUSY
);

  logic [0:0]             state_q,     state_d;
  logic [N_SRC-1:0]       grant_q,     grant_d;
  logic [SRC_W-1:0]       grant_id_q,  grant_id_d;
  logic [SRC_W-1:0]       rr_ptr_q,    rr_ptr_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [N_SRC-1:0]      req, preq;
  logic [N_SRC-1:0]      req_onehot, preq_onehot;
  logic [SRC_W-1:0]      req_idx, preq_idx;
  logic [DATA_WIDTH-1:0] src_data [N_SRC];

  logic             in_xfer, g_empty, g_preempt, transfer;
  logic             burst_last, other_preq, release_grant;
  logic [SRC_W-1:0] rr_next;

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_data[i] = SRC_FIFO_DATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req  = SRC_ENABLE & ~SRC_FIFO_EMPTY;
  assign preq = req & SRC_FIFO_PREEMPT_REQ;

  rr_priority_select #(.N(N_SRC), .W(SRC_W)) u_sel_preq (
    .req_i    (preq),
    .ptr_i    (rr_ptr_q),
    .onehot_o (preq_onehot),
    .idx_o    (preq_idx)
  );

  rr_priority_select #(.N(N_SRC), .W(SRC_W)) u_sel_req (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (req_onehot),
    .idx_o    (req_idx)
  );

  assign in_xfer   = (state_q == ST_XFER);
  assign g_empty   = SRC_FIFO_EMPTY[grant_id_q];
  assign g_preempt = SRC_FIFO_PREEMPT_REQ[grant_id_q];

  assign OUT_VALID     = in_xfer & ~g_empty;
  assign transfer      = OUT_VALID & OUT_READY;
  assign SRC_FIFO_READ = transfer ? grant_q : '0;
  assign OUT_DATA      = (|grant_q) ? src_data[grant_id_q] : '0;
  assign GRANT         = grant_q;
  assign GRANT_ID      = grant_id_q;
  assign BUSY          = in_xfer;

  // A preempting owner ignores both the burst limit and competing preemptors.
  assign burst_last    = (({1'b0, burst_cnt_q} + 1'b1) == (BURST_CNT_W + 1)'(MAX_BURST));
  assign other_preq    = |(preq & ~grant_q);
  assign release_grant = g_empty | (transfer & ~g_preempt & (burst_last | other_preq));
  assign rr_next       = (grant_id_q == SRC_W'(N_SRC - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d     = ST_XFER;
          burst_cnt_d = '0;
          if (|preq) begin
            grant_d    = preq_onehot;
            grant_id_d = preq_idx;
          end else begin
            grant_d    = req_onehot;
            grant_id_d = req_idx;
          end
        end
      end
      ST_XFER: begin
        if (transfer && (burst_cnt_q != BURST_SAT)) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if (release_grant) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          rr_ptr_d   = rr_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlu_readout_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tlu_readout_arbiter: queue-modelled FIFO sources, randomized traffic,
// scoreboarded against a transaction-level arbitration model.  Rev 1.0
// ------------------------------------------------------------------
module tb_tlu_readout_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXB = 4;
  localparam int SW   = 2;

  logic            BUS_CLK   = 1'b0;
  logic            BUS_RST_N = 1'b0;
  logic [N-1:0]    SRC_ENABLE, SRC_FIFO_EMPTY, SRC_FIFO_PREEMPT_REQ, SRC_FIFO_READ, GRANT;
  logic [N*DW-1:0] SRC_FIFO_DATA;
  logic [DW-1:0]   OUT_DATA;
  logic            OUT_VALID, OUT_READY, BUSY;
  logic [SW-1:0]   GRANT_ID;

  tlu_readout_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .BUS_CLK              (BUS_CLK),
    .BUS_RST_N            (BUS_RST_N),
    .SRC_ENABLE           (SRC_ENABLE),
    .SRC_FIFO_EMPTY       (SRC_FIFO_EMPTY),
    .SRC_FIFO_DATA        (SRC_FIFO_DATA),
    .SRC_FIFO_PREEMPT_REQ (SRC_FIFO_PREEMPT_REQ),
    .SRC_FIFO_READ        (SRC_FIFO_READ),
    .OUT_DATA             (OUT_DATA),
    .OUT_VALID            (OUT_VALID),
    .OUT_READY            (OUT_READY),
    .GRANT                (GRANT),
    .GRANT_ID             (GRANT_ID),
    .BUSY                 (BUSY)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  logic [DW-1:0] fifo [N][$];
  logic [DW-1:0] expq [N][$];
  logic [N-1:0]  exp_grant_q [$];
  int            grant_log [$];
  int            len_log [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            seq      = 0;

  // Arbitration model: owner (-1 when idle), round-robin pointer, words this grant.
  int            m_g = -1, m_ptr = 0, m_cnt = 0, prev_g = -1, wcnt = 0, mon_id = 0;
  logic [N-1:0]  m_req, m_preq, last_grant = '0;
  logic          m_valid, m_fire, m_rel, prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic int first_from(input logic [N-1:0] v, input int ptr);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic string log_str();
    string s;
    s = "";
    for (int i = 0; i < grant_log.size(); i++) begin
      if (i > 0) s = {s, " "};
      s = {s, $sformatf("%0d:", grant_log[i])};
      if (i < len_log.size()) s = {s, $sformatf("%0d", len_log[i])};
      else s = {s, "?"};
    end
    return s;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (fifo[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      SRC_FIFO_EMPTY[i] = (fifo[i].size() == 0);
      SRC_FIFO_DATA[i*DW +: DW] = (fifo[i].size() == 0) ? (32'hDEAD_0000 + 32'(i)) : fifo[i][0];
    end
  endtask

  task automatic push_n(input int src, input int n);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = {8'(src), 24'(seq)};
      seq++;
      fifo[src].push_back(w);
      expq[src].push_back(w);
    end
  endtask

  // The FIFO models pop whatever the DUT strobed just before the edge.
  task automatic cycle();
    logic [N-1:0] pops;
    @(negedge BUS_CLK);
    pops = SRC_FIFO_READ;
    @(posedge BUS_CLK);
    #1;
    if (BUS_RST_N) begin
      for (int i = 0; i < N; i++) if (pops[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
    end
    refresh();
  endtask

  task automatic drain(input string name, input int budget);
    int t;
    t = 0;
    while (!(all_empty() && GRANT == '0) && t < budget) begin
      cycle();
      t++;
    end
    if (t >= budget) fail_now(name);
    repeat (2) cycle();
  endtask

  task automatic clear_logs();
    grant_log.delete();
    len_log.delete();
  endtask

  always @(negedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      chk("reset_outputs", 64'({SRC_FIFO_READ, GRANT, GRANT_ID, OUT_VALID, BUSY, OUT_DATA}), 64'd0);
      m_g = -1; m_ptr = 0; m_cnt = 0;
      exp_grant_q.delete();
      exp_grant_q.push_back('0);
      prev_hold = 1'b0; last_grant = '0; wcnt = 0;
    end else begin
      if (exp_grant_q.size() > 0) chk("grant", 64'(GRANT), 64'(exp_grant_q.pop_front()));
      chk("grant_id", 64'(GRANT_ID), (m_g < 0) ? 64'd0 : 64'(m_g));
      chk("busy", 64'(BUSY), 64'(m_g >= 0));
      m_req   = SRC_ENABLE & ~SRC_FIFO_EMPTY;
      m_preq  = m_req & SRC_FIFO_PREEMPT_REQ;
      m_valid = (m_g >= 0) ? !SRC_FIFO_EMPTY[m_g] : 1'b0;
      m_fire  = m_valid && OUT_READY;
      chk("out_valid", 64'(OUT_VALID), 64'(m_valid));
      chk("fifo_read", 64'(SRC_FIFO_READ), 64'(m_fire ? onehot(m_g) : '0));
      chk("read_while_empty", 64'(SRC_FIFO_READ & SRC_FIFO_EMPTY), 64'd0);
      if (GRANT == '0) chk("data_idle_zero", 64'(OUT_DATA), 64'd0);
      if (prev_hold && prev_g == m_g) chk("data_stable", 64'(OUT_DATA), 64'(prev_data));
      if (OUT_VALID && OUT_READY) begin
        mon_id = int'(GRANT_ID);
        if (expq[mon_id].size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out_data: got %0h from src %0d expected no word", OUT_DATA, mon_id);
        end else begin
          chk("out_data", 64'(OUT_DATA), 64'(expq[mon_id].pop_front()));
        end
      end
      if (GRANT != '0 && last_grant == '0) begin
        grant_log.push_back(int'(GRANT_ID));
        wcnt = 0;
      end else if (GRANT == '0 && last_grant != '0) begin
        len_log.push_back(wcnt);
      end
      if (OUT_VALID && OUT_READY) wcnt++;
      last_grant = GRANT;
      prev_hold  = m_valid && !OUT_READY;
      prev_data  = OUT_DATA;
      prev_g     = m_g;
      // Predict next cycle's owner from the arbitration rules.
      if (m_g < 0) begin
        if (m_req != '0) begin
          m_g   = first_from((m_preq != '0) ? m_preq : m_req, m_ptr);
          m_cnt = 0;
        end
      end else begin
        m_rel = !m_valid || (m_fire && !SRC_FIFO_PREEMPT_REQ[m_g] &&
                ((m_cnt + 1 == MAXB) || ((m_preq & ~onehot(m_g)) != '0)));
        if (m_fire && m_cnt < 255) m_cnt++;
        if (m_rel) begin
          m_ptr = (m_g + 1) % N;
          m_g   = -1;
        end
      end
      exp_grant_q.push_back(onehot(m_g));
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int t, sz, idx, total;
    logic [3:0] pat;
    SRC_ENABLE = '1;
    SRC_FIFO_PREEMPT_REQ = '0;
    OUT_READY = 1'b0;
    refresh();
    repeat (3) cycle();
    BUS_RST_N = 1'b1;
    cycle();
    chk("idle_after_reset", 64'({GRANT, BUSY, OUT_VALID}), 64'd0);

    // Single source, three words.
    OUT_READY = 1'b1;
    clear_logs();
    push_n(1, 3);
    refresh();
    cycle();
    chk("single_grant", 64'(GRANT), 64'(4'b0010));
    drain("single_drain", 20);
    chk_str("single_log", log_str(), "1:3");

    // Two always-busy sources alternate in MAXB-word bursts, starting after src1.
    clear_logs();
    push_n(0, 12);
    push_n(3, 12);
    refresh();
    drain("burst_drain", 200);
    chk_str("burst_log", log_str(), "3:4 0:4 3:4 0:4 3:4 0:4");

    // src2 preempts src0 mid-burst and keeps the grant for all 20 words.
    clear_logs();
    push_n(0, 10);
    refresh();
    t = 0;
    while (fifo[0].size() != 8 && t < 20) begin cycle(); t++; end
    if (t >= 20) fail_now("preempt_wait");
    SRC_FIFO_PREEMPT_REQ[2] = 1'b1;
    push_n(2, 20);
    refresh();
    drain("preempt_drain", 200);
    SRC_FIFO_PREEMPT_REQ = '0;
    chk_str("preempt_log", log_str(), "0:3 2:20 0:4 0:3");

    // Backpressure with READY pattern 1,0,0,1 once granted.
    clear_logs();
    OUT_READY = 1'b0;
    push_n(1, 4);
    refresh();
    t = 0;
    while (GRANT == '0 && t < 10) begin cycle(); t++; end
    if (t >= 10) fail_now("bp_grant_wait");
    pat = 4'b1001;
    for (int k = 3; k >= 0; k--) begin
      OUT_READY = pat[k];
      cycle();
    end
    chk("bp_pops", 64'(fifo[1].size()), 64'd2);
    OUT_READY = 1'b1;
    drain("bp_drain", 50);
    chk_str("bp_log", log_str(), "1:4");

    // A masked source is never granted even though it has data.
    clear_logs();
    SRC_ENABLE = 4'b1101;
    push_n(1, 5);
    push_n(0, 3);
    refresh();
    t = 0;
    while (!(fifo[0].size() == 0 && GRANT == '0) && t < 40) begin cycle(); t++; end
    if (t >= 40) fail_now("mask_wait");
    repeat (10) cycle();
    chk_str("mask_log", log_str(), "0:3");
    chk("mask_src1_kept", 64'(fifo[1].size()), 64'd5);
    SRC_ENABLE = '1;
    refresh();
    drain("mask_drain", 100);

    // Randomized traffic, masks, preemption and backpressure.
    clear_logs();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) push_n(i, int'($urandom_range(1, 3)));
      OUT_READY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        idx = int'($urandom_range(0, N - 1));
        SRC_FIFO_PREEMPT_REQ[idx] = ~SRC_FIFO_PREEMPT_REQ[idx];
      end
      if ($urandom_range(0, 59) == 0) SRC_ENABLE = 4'($urandom);
      refresh();
      cycle();
    end
    SRC_FIFO_PREEMPT_REQ = '0;
    SRC_ENABLE = '1;
    OUT_READY = 1'b1;
    refresh();
    drain("random_drain", 3000);

    // Asynchronous reset in the middle of a burst.
    clear_logs();
    push_n(3, 10);
    refresh();
    t = 0;
    cycle();
    #1;
    while (SRC_FIFO_READ == '0 && t < 20) begin cycle(); #1; t++; end
    if (t >= 20) fail_now("rst_wait_read");
    sz = fifo[3].size();
    BUS_RST_N = 1'b0;
    #1;
    chk("rst_async_read", 64'(SRC_FIFO_READ), 64'd0);
    chk("rst_async_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_async_grant", 64'(GRANT), 64'd0);
    chk("rst_async_busy", 64'(BUSY), 64'd0);
    repeat (3) cycle();
    chk("rst_words_kept", 64'(fifo[3].size()), 64'(sz));
    BUS_RST_N = 1'b1;
    drain("rst_drain", 100);

    total = 0;
    for (int i = 0; i < N; i++) total += expq[i].size();
    chk("all_words_delivered", 64'(total), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
